iic_slave_reg: RTL and testbench

IIC_SLAVE_REG -- requirements
Module: iic_slave_reg

---
 rtl/iic_slave_reg.sv | 206 ++++++++++++++++++++
 tb/tb_iic_slave_reg.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_slave_reg.sv
// IIC register-access slave: filtered SCL/SDA decoding, one-byte word pointer,
// single-cycle write/read strobes towards a user register file.
module iic_slave_reg #(
    parameter logic [6:0] DEV_AD  = 7'b101_0000,
    parameter int         FLT_LEN = 3
) (
    input  logic       CLK_IN,
    input  logic       RESET_IN,
    input  logic       IIC_SCL_IN,
    input  logic       IIC_SDA_IN,
    output logic       IIC_SDA_OE,
    output logic [7:0] REG_ADDR,
    output logic [7:0] REG_WD,
    output logic       REG_WE,
    output logic       REG_RE,
    input  logic [7:0] REG_RD,
    output logic       IIC_BUSY
);

    localparam int            CW       = $clog2(FLT_LEN + 1);
    localparam logic [CW-1:0] FLT_LAST = CW'(FLT_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, DEV_ADR, DEV_ACK, WORD_ADR, WORD_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    // bit 0 carries SCL, bit 1 carries SDA through synchronizer and filter
    logic [1:0]         sync1, sync2, filt, filt_d;
    logic [1:0][CW-1:0] flt_cnt;

    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift;
    logic       rw;
    logic       master_ack;
    logic       rd_cap;

    logic scl_rise, scl_fall, start_cond, stop_cond, sda;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            sync1   <= 2'b11;
            sync2   <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            flt_cnt <= '0;
        end else begin
            sync1  <= {IIC_SDA_IN, IIC_SCL_IN};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_LAST) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign sda        = filt[1];
    assign scl_rise   = filt[0] & ~filt_d[0];
    assign scl_fall   = ~filt[0] & filt_d[0];
    assign start_cond = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
    assign stop_cond  = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            shift      <= 8'h00;
            rw         <= 1'b0;
            master_ack <= 1'b0;
            rd_cap     <= 1'b0;
            IIC_SDA_OE <= 1'b0;
            REG_ADDR   <= 8'h00;
            REG_WD     <= 8'h00;
            REG_WE     <= 1'b0;
            REG_RE     <= 1'b0;
            IIC_BUSY   <= 1'b0;
        end else begin
            REG_WE <= 1'b0;
            REG_RE <= 1'b0;
            rd_cap <= REG_RE;
            if (start_cond) begin
                state      <= DEV_ADR;
                bit_cnt    <= 4'd0;
                IIC_SDA_OE <= 1'b0;
                rd_cap     <= 1'b0;
            end else if (stop_cond) begin
                state      <= IDLE;
                bit_cnt    <= 4'd0;
                IIC_SDA_OE <= 1'b0;
                IIC_BUSY   <= 1'b0;
                rd_cap     <= 1'b0;
            end else if (rd_cap && state == RD_DATA) begin
                // user data arrived during the SCL low phase; present its MSB
                shift      <= REG_RD;
                IIC_SDA_OE <= ~REG_RD[7];
            end else begin
                case (state)
                    DEV_ADR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shift[7:1] == DEV_AD) begin
                                state      <= DEV_ACK;
                                IIC_SDA_OE <= 1'b1;
                                IIC_BUSY   <= 1'b1;
                                rw         <= shift[0];
                            end else begin
                                state    <= WAIT_STOP;
                                IIC_BUSY <= 1'b0;
                            end
                        end
                    end
                    DEV_ACK: begin
                        if (scl_fall) begin
                            IIC_SDA_OE <= 1'b0;
                            if (rw) begin
                                state  <= RD_DATA;
                                REG_RE <= 1'b1;
                            end else begin
                                state <= WORD_ADR;
                            end
                        end
                    end
                    WORD_ADR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            REG_ADDR   <= shift;
                            state      <= WORD_ACK;
                            IIC_SDA_OE <= 1'b1;
                            bit_cnt    <= 4'd0;
                        end
                    end
                    WORD_ACK: begin
                        if (scl_fall) begin
                            IIC_SDA_OE <= 1'b0;
                            state      <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                REG_WD <= {shift[6:0], sda};
                                REG_WE <= 1'b1;
                            end
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            state      <= WR_ACK;
                            IIC_SDA_OE <= 1'b1;
                            bit_cnt    <= 4'd0;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            IIC_SDA_OE <= 1'b0;
                            REG_ADDR   <= REG_ADDR + 8'd1;
                            state      <= WR_DATA;
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                state      <= RD_ACK;
                                IIC_SDA_OE <= 1'b0;
                                bit_cnt    <= 4'd0;
                            end else begin
                                IIC_SDA_OE <= ~shift[7];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            master_ack <= ~sda;
                        end else if (scl_fall) begin
                            REG_ADDR <= REG_ADDR + 8'd1;
                            if (master_ack) begin
                                state  <= RD_DATA;
                                REG_RE <= 1'b1;
                            end else begin
                                state    <= WAIT_STOP;
                                IIC_BUSY <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_reg.sv
// Directed bench for iic_slave_reg: a bit-banged IIC master plus a registered
// user register file that returns the inverted address on reads.
`timescale 1ns/100ps
module tb_iic_slave_reg;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       master_scl, master_sda;
    logic       sda_bus;
    logic       oe;
    logic [7:0] reg_addr, reg_wd, reg_rd;
    logic       reg_we, reg_re, busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] we_addr_q[$];
    logic [7:0] we_data_q[$];
    logic [7:0] re_addr_q[$];
    int         oe_seen, busy_seen, scl_high_drive;
    logic       oe_prev = 1'b0;

    always #2.5 clk = ~clk;

    assign sda_bus = master_sda & ~oe;

    iic_slave_reg dut (
        .CLK_IN     (clk),
        .RESET_IN   (rst),
        .IIC_SCL_IN (master_scl),
        .IIC_SDA_IN (sda_bus),
        .IIC_SDA_OE (oe),
        .REG_ADDR   (reg_addr),
        .REG_WD     (reg_wd),
        .REG_WE     (reg_we),
        .REG_RE     (reg_re),
        .REG_RD     (reg_rd),
        .IIC_BUSY   (busy)
    );

    // registered user memory: data valid the cycle after the read strobe
    always @(posedge clk) begin
        if (reg_re) reg_rd <= ~reg_addr;
    end

    always @(negedge clk) begin
        if (reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wd);
        end
        if (reg_re) re_addr_q.push_back(reg_addr);
        if (oe) oe_seen++;
        if (busy) busy_seen++;
        if (oe && !oe_prev && master_scl) scl_high_drive++;
        oe_prev = oe;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitors();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
        oe_seen   = 0;
        busy_seen = 0;
    endtask

    task automatic i2c_start();
        master_sda = 1'b1; tick(Q);
        master_scl = 1'b1; tick(Q);
        master_sda = 1'b0; tick(Q);
        master_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        master_sda = 1'b0; tick(Q);
        master_scl = 1'b1; tick(Q);
        master_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        master_sda = b; tick(Q);
        master_scl = 1'b1;
        if (glitch) begin
            tick(Q);
            master_scl = 1'b0; tick(2);
            master_scl = 1'b1; tick(Q - 2);
        end else begin
            tick(2 * Q);
        end
        master_scl = 1'b0; tick(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
        master_sda = 1'b1; tick(Q);
        master_scl = 1'b1; tick(Q);
        ack = sda_bus;     tick(Q);
        master_scl = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            master_sda = 1'b1; tick(Q);
            master_scl = 1'b1; tick(Q);
            d[i] = sda_bus;    tick(Q);
            master_scl = 1'b0; tick(Q);
        end
        send_bit(~give_ack, 1'b0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         waited;

        rst = 1'b1; master_scl = 1'b1; master_sda = 1'b1;
        tick(5);
        check_output("rst_oe", oe, 1'b0);
        check_output("rst_we", reg_we, 1'b0);
        check_output("rst_re", reg_re, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_addr", reg_addr, 8'h00);
        check_output("rst_wd", reg_wd, 8'h00);
        rst = 1'b0;
        tick(10);

        $display("[TB] two-byte write at 0x10");
        clear_monitors();
        i2c_start();
        send_byte(8'hA0, -1, ack); check_output("wr_dev_ack", ack, 1'b0);
        check_output("wr_busy", busy, 1'b1);
        send_byte(8'h10, -1, ack); check_output("wr_word_ack", ack, 1'b0);
        send_byte(8'h5A, -1, ack); check_output("wr_d0_ack", ack, 1'b0);
        send_byte(8'h3C, -1, ack); check_output("wr_d1_ack", ack, 1'b0);
        i2c_stop();
        check_output("wr_we_count", we_addr_q.size(), 2);
        if (we_addr_q.size() == 2) begin
            check_output("wr_we0_addr", we_addr_q[0], 8'h10);
            check_output("wr_we0_data", we_data_q[0], 8'h5A);
            check_output("wr_we1_addr", we_addr_q[1], 8'h11);
            check_output("wr_we1_data", we_data_q[1], 8'h3C);
        end
        check_output("wr_final_addr", reg_addr, 8'h12);
        check_output("wr_busy_after_stop", busy, 1'b0);

        $display("[TB] random read at 0xFE with wrap");
        clear_monitors();
        i2c_start();
        send_byte(8'hA0, -1, ack); check_output("rd_dev_ack", ack, 1'b0);
        send_byte(8'hFE, -1, ack); check_output("rd_word_ack", ack, 1'b0);
        i2c_start();
        send_byte(8'hA1, -1, ack); check_output("rd_dev_ack_r", ack, 1'b0);
        read_byte(1'b1, d); check_output("rd_byte0", d, 8'h01);
        read_byte(1'b1, d); check_output("rd_byte1", d, 8'h00);
        read_byte(1'b0, d); check_output("rd_byte2", d, 8'hFF);
        check_output("rd_busy_after_nack", busy, 1'b0);
        i2c_stop();
        check_output("rd_re_count", re_addr_q.size(), 3);
        if (re_addr_q.size() == 3) begin
            check_output("rd_re0_addr", re_addr_q[0], 8'hFE);
            check_output("rd_re1_addr", re_addr_q[1], 8'hFF);
            check_output("rd_re2_addr", re_addr_q[2], 8'h00);
        end
        check_output("rd_we_count", we_addr_q.size(), 0);
        check_output("rd_final_addr", reg_addr, 8'h01);

        $display("[TB] foreign device address");
        clear_monitors();
        i2c_start();
        send_byte(8'hB0, -1, ack); check_output("mm_dev_nack", ack, 1'b1);
        send_byte(8'h22, -1, ack); check_output("mm_word_nack", ack, 1'b1);
        i2c_stop();
        check_output("mm_oe_seen", oe_seen, 0);
        check_output("mm_busy_seen", busy_seen, 0);
        check_output("mm_we_count", we_addr_q.size(), 0);
        check_output("mm_re_count", re_addr_q.size(), 0);
        check_output("mm_addr_kept", reg_addr, 8'h01);

        $display("[TB] SCL glitch inside a data bit");
        clear_monitors();
        i2c_start();
        send_byte(8'hA0, -1, ack); check_output("gl_dev_ack", ack, 1'b0);
        send_byte(8'h40, -1, ack); check_output("gl_word_ack", ack, 1'b0);
        send_byte(8'h96, 3, ack);  check_output("gl_data_ack", ack, 1'b0);
        i2c_stop();
        check_output("gl_we_count", we_addr_q.size(), 1);
        if (we_addr_q.size() == 1) begin
            check_output("gl_we_addr", we_addr_q[0], 8'h40);
            check_output("gl_we_data", we_data_q[0], 8'h96);
        end
        check_output("gl_final_addr", reg_addr, 8'h41);

        $display("[TB] STOP after four data bits");
        clear_monitors();
        i2c_start();
        send_byte(8'hA0, -1, ack); check_output("ab_dev_ack", ack, 1'b0);
        send_byte(8'h20, -1, ack); check_output("ab_word_ack", ack, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        i2c_stop();
        check_output("ab_we_count", we_addr_q.size(), 0);
        check_output("ab_addr", reg_addr, 8'h20);
        check_output("ab_busy", busy, 1'b0);
        i2c_start();
        send_byte(8'hA0, -1, ack); check_output("ab2_dev_ack", ack, 1'b0);
        send_byte(8'h30, -1, ack); check_output("ab2_word_ack", ack, 1'b0);
        send_byte(8'h77, -1, ack); check_output("ab2_data_ack", ack, 1'b0);
        i2c_stop();
        check_output("ab2_we_count", we_addr_q.size(), 1);
        if (we_addr_q.size() == 1) begin
            check_output("ab2_we_addr", we_addr_q[0], 8'h30);
            check_output("ab2_we_data", we_data_q[0], 8'h77);
        end

        $display("[TB] reset while driving a read zero bit");
        i2c_start();
        send_byte(8'hA0, -1, ack); check_output("rs_dev_ack", ack, 1'b0);
        send_byte(8'h80, -1, ack); check_output("rs_word_ack", ack, 1'b0);
        i2c_stop();
        check_output("rs_addr_set", reg_addr, 8'h80);
        i2c_start();
        send_byte(8'hA1, -1, ack); check_output("rs_dev_ack_r", ack, 1'b0);
        waited = 0;
        while (!oe && waited < 40) begin
            tick(1);
            waited++;
        end
        check_output("rs_bit0_driven", oe, 1'b1);
        rst = 1'b1;
        #0.5;
        check_output("rs_oe_async", oe, 1'b0);
        check_output("rs_busy", busy, 1'b0);
        check_output("rs_we", reg_we, 1'b0);
        check_output("rs_re", reg_re, 1'b0);
        check_output("rs_addr", reg_addr, 8'h00);
        check_output("rs_wd", reg_wd, 8'h00);
        tick(3);
        rst = 1'b0;
        master_sda = 1'b1;
        tick(Q);

        clear_monitors();
        i2c_start();
        send_byte(8'hA0, -1, ack); check_output("pr_dev_ack", ack, 1'b0);
        send_byte(8'h05, -1, ack); check_output("pr_word_ack", ack, 1'b0);
        send_byte(8'hC3, -1, ack); check_output("pr_data_ack", ack, 1'b0);
        i2c_stop();
        check_output("pr_we_count", we_addr_q.size(), 1);
        if (we_addr_q.size() == 1) begin
            check_output("pr_we_addr", we_addr_q[0], 8'h05);
            check_output("pr_we_data", we_data_q[0], 8'hC3);
        end
        check_output("pr_final_addr", reg_addr, 8'h06);
        check_output("no_drive_scl_high", scl_high_drive, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
